// File: rtl/nbody_step_sequencer_pkg.sv
// Shared types and default pipeline latencies for the n-body step sequencer.
package nbody_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ACCEL       = 3'd1,
    ACCEL_DRAIN = 3'd2,
    POS         = 3'd3,
    POS_DRAIN   = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam int MULT_TIME    = 11;
  localparam int ADD_TIME     = 20;
  localparam int INVSQRT_TIME = 27;
  localparam int RAM_LAT      = 1;

  // getAccl: RAM read, five multiply stages, two add stages and the inverse sqrt.
  localparam int ACCL_LAT_DEFAULT = RAM_LAT + 5 * MULT_TIME + 2 * ADD_TIME + INVSQRT_TIME;
  localparam int POS_LAT_DEFAULT  = RAM_LAT + ADD_TIME;

endpackage

// File: rtl/nbody_step_sequencer_if.sv
// Control and datapath-facing signal bundle of the step sequencer.
interface nbody_step_sequencer_if #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int STEP_WIDTH      = 16
);
  logic                       start;
  logic                       abort;
  logic                       done_ack;
  logic [BODY_ADDR_WIDTH:0]   num_bodies;
  logic [STEP_WIDTH-1:0]      num_steps;
  logic                       busy;
  logic                       done;
  logic [STEP_WIDTH-1:0]      step_count;
  logic                       pair_valid;
  logic [BODY_ADDR_WIDTH-1:0] pair_i;
  logic [BODY_ADDR_WIDTH-1:0] pair_j;
  logic                       pair_self;
  logic                       acc_valid;
  logic                       acc_first;
  logic                       acc_last;
  logic [BODY_ADDR_WIDTH-1:0] acc_body;
  logic                       pos_rd_en;
  logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr;
  logic                       pos_wr_en;
  logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr;

  modport master (
    input  start, abort, done_ack, num_bodies, num_steps,
    output busy, done, step_count, pair_valid, pair_i, pair_j, pair_self,
           acc_valid, acc_first, acc_last, acc_body,
           pos_rd_en, pos_rd_addr, pos_wr_en, pos_wr_addr
  );

  modport slave (
    output start, abort, done_ack, num_bodies, num_steps,
    input  busy, done, step_count, pair_valid, pair_i, pair_j, pair_self,
           acc_valid, acc_first, acc_last, acc_body,
           pos_rd_en, pos_rd_addr, pos_wr_en, pos_wr_addr
  );
endinterface

// File: rtl/nbody_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to re-time tags to pipeline outputs.
module nbody_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; clear flushes every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < DEPTH; k++) stage_r[k] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage_r[k] <= stage_r[k-1];
    end
  end

  assign dout = stage_r[DEPTH-1];
endmodule

// File: rtl/nbody_step_sequencer.sv
// Pair-stream / position-sweep sequencer for the n-body step engine.
module nbody_step_sequencer
  import nbody_pkg::*;
#(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int ACCL_LATENCY    = ACCL_LAT_DEFAULT,
  parameter int POS_LATENCY     = POS_LAT_DEFAULT,
  parameter int STEP_WIDTH      = 16
) (
  input logic                  clk,
  input logic                  rst,
  nbody_step_sequencer_if.master bus
);
  localparam int AW      = BODY_ADDR_WIDTH;
  localparam int CNT_MAX = (ACCL_LATENCY > POS_LATENCY) ? ACCL_LATENCY : POS_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW:0]         A_ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0]         A_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0]       C_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]       C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       ACC_END  = CW'(ACCL_LATENCY - 1);
  localparam logic [CW-1:0]       POS_END  = CW'(POS_LATENCY - 1);
  localparam logic [STEP_WIDTH-1:0] S_ZERO = {STEP_WIDTH{1'b0}};
  localparam logic [STEP_WIDTH-1:0] S_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [AW:0]           i_r, i_s, j_r, j_s, n_r, n_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [STEP_WIDTH-1:0] step_r, step_s, s_r, s_s;

  // Counters are one bit wider than a body index so n == BODIES compares cleanly.
  logic [AW:0]           n_m1_s;
  logic [STEP_WIDTH-1:0] step_inc_s;
  logic                  abort_s;
  logic                  pair_valid_s, first_s, last_s;
  logic [AW-1:0]         pair_i_s, pair_j_s;
  logic [AW+2:0]         acc_din_s, acc_dout_s;
  logic [AW:0]           pos_din_s, pos_dout_s;

  assign n_m1_s     = n_r - A_ONE;
  assign step_inc_s = step_r + S_ONE;
  assign abort_s    = bus.abort && (state_r != IDLE);

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    cnt_s   = cnt_r;
    step_s  = step_r;
    n_s     = n_r;
    s_s     = s_r;
    if (abort_s) begin
      state_s = IDLE;
      i_s     = A_ZERO;
      j_s     = A_ZERO;
      cnt_s   = C_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            n_s    = bus.num_bodies;
            s_s    = bus.num_steps;
            step_s = S_ZERO;
            i_s    = A_ZERO;
            j_s    = A_ZERO;
            cnt_s  = C_ZERO;
            if ((bus.num_bodies == A_ZERO) || (bus.num_steps == S_ZERO)) state_s = DONE;
            else state_s = ACCEL;
          end else begin
            state_s = IDLE;
          end
        end
        ACCEL: begin
          if (j_r == n_m1_s) begin
            j_s = A_ZERO;
            if (i_r == n_m1_s) begin
              i_s     = A_ZERO;
              cnt_s   = C_ZERO;
              state_s = ACCEL_DRAIN;
            end else begin
              i_s = i_r + A_ONE;
            end
          end else begin
            j_s = j_r + A_ONE;
          end
        end
        ACCEL_DRAIN: begin
          if (cnt_r == ACC_END) begin
            cnt_s   = C_ZERO;
            i_s     = A_ZERO;
            state_s = POS;
          end else begin
            cnt_s = cnt_r + C_ONE;
          end
        end
        POS: begin
          if (i_r == n_m1_s) begin
            i_s     = A_ZERO;
            cnt_s   = C_ZERO;
            state_s = POS_DRAIN;
          end else begin
            i_s = i_r + A_ONE;
          end
        end
        POS_DRAIN: begin
          if (cnt_r == POS_END) begin
            cnt_s  = C_ZERO;
            step_s = step_inc_s;
            if (step_inc_s == s_r) state_s = DONE;
            else state_s = ACCEL;
          end else begin
            cnt_s = cnt_r + C_ONE;
          end
        end
        DONE: begin
          if (bus.done_ack) state_s = IDLE;
          else state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      i_r     <= A_ZERO;
      j_r     <= A_ZERO;
      n_r     <= A_ZERO;
      cnt_r   <= C_ZERO;
      step_r  <= S_ZERO;
      s_r     <= S_ZERO;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      n_r     <= n_s;
      cnt_r   <= cnt_s;
      step_r  <= step_s;
      s_r     <= s_s;
    end
  end

  assign pair_valid_s = (state_r == ACCEL);
  assign pair_i_s     = pair_valid_s ? i_r[AW-1:0] : {AW{1'b0}};
  assign pair_j_s     = pair_valid_s ? j_r[AW-1:0] : {AW{1'b0}};
  assign first_s      = pair_valid_s && (j_r == A_ZERO);
  assign last_s       = pair_valid_s && (j_r == n_m1_s);

  assign bus.busy        = (state_r != IDLE) && (state_r != DONE);
  assign bus.done        = (state_r == DONE);
  assign bus.step_count  = step_r;
  assign bus.pair_valid  = pair_valid_s;
  assign bus.pair_i      = pair_i_s;
  assign bus.pair_j      = pair_j_s;
  assign bus.pair_self   = pair_valid_s && (i_r == j_r);
  assign bus.pos_rd_en   = (state_r == POS);
  assign bus.pos_rd_addr = (state_r == POS) ? i_r[AW-1:0] : {AW{1'b0}};

  assign acc_din_s = {pair_valid_s, first_s, last_s, pair_i_s};
  assign pos_din_s = {bus.pos_rd_en, bus.pos_rd_addr};

  nbody_delay_line #(.WIDTH(AW + 3), .DEPTH(ACCL_LATENCY)) u_acc_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort_s),
    .din  (acc_din_s),
    .dout (acc_dout_s)
  );

  nbody_delay_line #(.WIDTH(AW + 1), .DEPTH(POS_LATENCY)) u_pos_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort_s),
    .din  (pos_din_s),
    .dout (pos_dout_s)
  );

  assign {bus.acc_valid, bus.acc_first, bus.acc_last, bus.acc_body} = acc_dout_s;
  assign {bus.pos_wr_en, bus.pos_wr_addr}                           = pos_dout_s;
endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Directed bench for nbody_step_sequencer with small latencies and a reduced body maximum.
module tb_nbody_step_sequencer;
  localparam int BODIES = 64;
  localparam int AW     = 6;
  localparam int L      = 5;
  localparam int P      = 3;
  localparam int SW     = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   self_seen;

  nbody_step_sequencer_if #(.BODY_ADDR_WIDTH(AW), .STEP_WIDTH(SW)) bus ();

  nbody_step_sequencer #(
    .BODIES(BODIES), .BODY_ADDR_WIDTH(AW), .ACCL_LATENCY(L),
    .POS_LATENCY(P), .STEP_WIDTH(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},   bus.busy,       32'd0);
    chk({tag, ".done"},   bus.done,       32'd0);
    chk({tag, ".pv"},     bus.pair_valid, 32'd0);
    chk({tag, ".av"},     bus.acc_valid,  32'd0);
    chk({tag, ".prd"},    bus.pos_rd_en,  32'd0);
    chk({tag, ".pwr"},    bus.pos_wr_en,  32'd0);
  endtask

  task automatic pulse_start(input int n, input int s);
    bus.num_bodies = (AW+1)'(n);
    bus.num_steps  = SW'(s);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Checks ncyc cycles of a run whose first pair is in the current cycle.
  task automatic run_check(input int n, input int s, input int ncyc);
    int t;
    t = n * n + L + n + P;
    for (int c = 0; c < ncyc; c++) begin
      int  l, a, pr, pw;
      bit  act, epv, eav, epr, epw;
      cyc = c;
      act = (c < s * t);
      l   = c % t;
      a   = l - L;
      pr  = l - (n * n + L);
      pw  = pr - P;
      epv = act && (l < n * n);
      eav = act && (a >= 0) && (a < n * n);
      epr = act && (pr >= 0) && (pr < n);
      epw = act && (pw >= 0) && (pw < n);
      if (bus.pair_self === 1'b1) self_seen++;
      chk("pair_valid", bus.pair_valid, epv);
      chk("pair_i",     bus.pair_i,     epv ? l / n : 0);
      chk("pair_j",     bus.pair_j,     epv ? l % n : 0);
      chk("pair_self",  bus.pair_self,  epv && (l / n == l % n));
      chk("acc_valid",  bus.acc_valid,  eav);
      chk("acc_body",   bus.acc_body,   eav ? a / n : 0);
      chk("acc_first",  bus.acc_first,  eav && (a % n == 0));
      chk("acc_last",   bus.acc_last,   eav && (a % n == n - 1));
      chk("pos_rd_en",  bus.pos_rd_en,  epr);
      chk("pos_rd_addr", bus.pos_rd_addr, epr ? pr : 0);
      chk("pos_wr_en",  bus.pos_wr_en,  epw);
      chk("pos_wr_addr", bus.pos_wr_addr, epw ? pw : 0);
      chk("busy",       bus.busy,       act);
      chk("done",       bus.done,       !act);
      chk("step_count", bus.step_count, act ? c / t : s);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.done_ack = 1'b0;
    bus.num_bodies = '0; bus.num_steps = '0;
    tick(); tick(); tick();
    chk_quiet("reset");
    chk("reset.step_count", bus.step_count, 32'd0);
    chk("reset.pair_self",  bus.pair_self,  32'd0);
    chk("reset.acc_body",   bus.acc_body,   32'd0);
    rst = 1'b0;
    tick();
    chk_quiet("idle");

    // Scenario 1: n=4, S=1; 16 pairs, done at cycle 28.
    self_seen = 0;
    pulse_start(4, 1);
    run_check(4, 1, 29);
    chk("s1.self_count", self_seen, 32'd4);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    chk_quiet("s1.ack");

    // Scenario 2: n=3, S=3; config changes mid-run ignored.
    pulse_start(3, 3);
    bus.num_bodies = 7'd7;
    bus.num_steps  = 16'd1;
    run_check(3, 3, 62);
    bus.done_ack = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    bus.start    = 1'b0;
    chk_quiet("s2.ack_with_start");
    tick();
    chk_quiet("s2.idle");

    // Scenario 3: abort during ACCEL_DRAIN, then restart with abort held (no effect in IDLE).
    pulse_start(4, 1);
    run_check(4, 1, 18);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_quiet("s3.abort");
    for (int k = 0; k < 12; k++) begin
      chk("s3.no_acc", bus.acc_valid, 32'd0);
      chk("s3.no_pwr", bus.pos_wr_en, 32'd0);
      tick();
    end
    bus.abort = 1'b1;
    pulse_start(4, 1);
    bus.abort = 1'b0;
    self_seen = 0;
    run_check(4, 1, 29);
    chk("s3.self_count", self_seen, 32'd4);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;

    // Scenario 4: n=0 and S=0 go straight to DONE.
    pulse_start(0, 5);
    chk("s4a.done", bus.done, 32'd1);
    chk("s4a.busy", bus.busy, 32'd0);
    chk("s4a.pv",   bus.pair_valid, 32'd0);
    chk("s4a.prd",  bus.pos_rd_en,  32'd0);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    chk_quiet("s4a.ack");
    pulse_start(4, 0);
    chk("s4b.done", bus.done, 32'd1);
    chk("s4b.pv",   bus.pair_valid, 32'd0);
    tick();
    chk("s4b.prd",  bus.pos_rd_en,  32'd0);
    chk("s4b.done_hold", bus.done, 32'd1);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    chk_quiet("s4b.ack");

    // Scenario 5: n=1.
    self_seen = 0;
    pulse_start(1, 1);
    run_check(1, 1, 11);
    chk("s5.self_count", self_seen, 32'd1);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;

    // Scenario 6: n=BODIES, reset asserted during POS.
    pulse_start(BODIES, 2);
    run_check(BODIES, 2, BODIES * BODIES + L + 3);
    chk("s6.in_pos", bus.pos_rd_en, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("s6.rst");
    chk("s6.step_count", bus.step_count, 32'd0);
    chk("s6.rd_addr",    bus.pos_rd_addr, 32'd0);
    chk("s6.wr_addr",    bus.pos_wr_addr, 32'd0);
    tick();
    chk_quiet("s6.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
